// File: rtl/triangle_rasterizer.sv
// Triangle rasterizer: latches one projected triangle, scans its bounding box one pixel
// per cycle and emits every pixel whose three edge functions agree in sign (either winding).
// Latency valid_in -> first pix_valid is 3 cycles; pix_valid/pix_ready stalls freeze the scan.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   valid_in, tri_in         triangle input, sampled only while busy_out==0
//   busy_out                 high while a triangle is in flight (SETUP..DONE)
//   pix_valid, pix_ready     pixel handshake
//   pix_x, pix_y             unsigned screen coordinates (vertex + 32)
//   pix_z, pix_color         flat depth and colour of the triangle
//   tri_done                 one-cycle pulse after the last pixel has drained
//   overflow                 sticky: a triangle arrived while busy and was dropped
module triangle_rasterizer #(
  parameter int COORD_W = 6,
  parameter int Z_W     = 9,
  parameter int COLOR_W = 10,
  parameter int TRI_W   = 6*COORD_W + Z_W + COLOR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic [TRI_W-1:0]   tri_in,
  output logic               busy_out,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [Z_W-1:0]     pix_z,
  output logic [COLOR_W-1:0] pix_color,
  output logic               tri_done,
  output logic               overflow
);

  localparam int DW = COORD_W + 1;      // edge delta width
  localparam int EW = 2*COORD_W + 3;    // edge function width, holds the full product sum

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t                    r_state;
  logic [COORD_W-1:0]        r_vx [3];
  logic [COORD_W-1:0]        r_vy [3];
  logic signed [DW-1:0]      r_dx [3];
  logic signed [DW-1:0]      r_dy [3];
  logic [Z_W-1:0]            r_z;
  logic [COLOR_W-1:0]        r_color;
  logic [COORD_W-1:0]        r_xmin, r_xmax, r_ymin, r_ymax;
  logic [COORD_W-1:0]        r_x, r_y;

  logic [COORD_W-1:0]        w_in_x [3];
  logic [COORD_W-1:0]        w_in_y [3];
  logic signed [DW-1:0]      w_dx [3];
  logic signed [DW-1:0]      w_dy [3];
  logic signed [EW-1:0]      w_area;
  logic signed [EW-1:0]      w_e [3];
  logic                      w_all_pos, w_all_neg, w_cov, w_adv;

  function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a, b, c);
    logic [COORD_W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a, b, c);
    logic [COORD_W-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // E = (px-ax)*dy - (py-ay)*dx, all operands widened to EW so nothing truncates
  function automatic logic signed [EW-1:0] edge_eval(
    input logic [COORD_W-1:0] px, py, ax, ay,
    input logic signed [DW-1:0] dx, dy
  );
    logic signed [EW-1:0] rx, ry, ex, ey;
    rx = $signed({{(EW-COORD_W){1'b0}}, px}) - $signed({{(EW-COORD_W){1'b0}}, ax});
    ry = $signed({{(EW-COORD_W){1'b0}}, py}) - $signed({{(EW-COORD_W){1'b0}}, ay});
    ex = {{(EW-DW){dx[DW-1]}}, dx};
    ey = {{(EW-DW){dy[DW-1]}}, dy};
    return rx*ey - ry*ex;
  endfunction

  // Unpack vertices; adding 32 to a 6-bit two's-complement value is just an MSB flip
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_in_x[i] = tri_in[TRI_W-1-(2*i)*COORD_W -: COORD_W];
      w_in_y[i] = tri_in[TRI_W-1-(2*i+1)*COORD_W -: COORD_W];
      w_in_x[i][COORD_W-1] = ~w_in_x[i][COORD_W-1];
      w_in_y[i][COORD_W-1] = ~w_in_y[i][COORD_W-1];
    end
  end

  // Edge i runs from vertex i to vertex (i+1)%3
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_dx[i] = $signed({1'b0, r_vx[(i+1)%3]}) - $signed({1'b0, r_vx[i]});
      w_dy[i] = $signed({1'b0, r_vy[(i+1)%3]}) - $signed({1'b0, r_vy[i]});
    end
    w_area = edge_eval(r_vx[2], r_vy[2], r_vx[0], r_vy[0], w_dx[0], w_dy[0]);
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_e[i] = edge_eval(r_x, r_y, r_vx[i], r_vy[i], r_dx[i], r_dy[i]);
    end
    w_all_pos = !w_e[0][EW-1] && !w_e[1][EW-1] && !w_e[2][EW-1];
    w_all_neg = (w_e[0][EW-1] || (w_e[0] == '0)) &&
                (w_e[1][EW-1] || (w_e[1] == '0)) &&
                (w_e[2][EW-1] || (w_e[2] == '0));
    w_cov = w_all_pos || w_all_neg;
    // Output slot is free when empty or being consumed this cycle
    w_adv = !pix_valid || pix_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      busy_out  <= 1'b0;
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_z     <= '0;
      pix_color <= '0;
      tri_done  <= 1'b0;
      overflow  <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_xmin    <= '0;
      r_xmax    <= '0;
      r_ymin    <= '0;
      r_ymax    <= '0;
      r_z       <= '0;
      r_color   <= '0;
      for (int i = 0; i < 3; i++) begin
        r_vx[i] <= '0;
        r_vy[i] <= '0;
        r_dx[i] <= '0;
        r_dy[i] <= '0;
      end
    end else begin
      tri_done <= 1'b0;
      if (valid_in && busy_out) overflow <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (valid_in) begin
            for (int i = 0; i < 3; i++) begin
              r_vx[i] <= w_in_x[i];
              r_vy[i] <= w_in_y[i];
            end
            r_z      <= tri_in[COLOR_W +: Z_W];
            r_color  <= tri_in[0 +: COLOR_W];
            busy_out <= 1'b1;
            r_state  <= S_SETUP;
          end
        end

        S_SETUP: begin
          for (int i = 0; i < 3; i++) begin
            r_dx[i] <= w_dx[i];
            r_dy[i] <= w_dy[i];
          end
          r_xmin  <= min3(r_vx[0], r_vx[1], r_vx[2]);
          r_xmax  <= max3(r_vx[0], r_vx[1], r_vx[2]);
          r_ymin  <= min3(r_vy[0], r_vy[1], r_vy[2]);
          r_ymax  <= max3(r_vy[0], r_vy[1], r_vy[2]);
          r_x     <= min3(r_vx[0], r_vx[1], r_vx[2]);
          r_y     <= min3(r_vy[0], r_vy[1], r_vy[2]);
          // Zero area covers collinear and single-point triangles alike
          r_state <= (w_area == '0) ? S_DONE : S_SCAN;
        end

        S_SCAN: begin
          if (w_adv) begin
            pix_valid <= w_cov;
            if (w_cov) begin
              pix_x     <= r_x;
              pix_y     <= r_y;
              pix_z     <= r_z;
              pix_color <= r_color;
            end
            if (r_x == r_xmax) begin
              r_x <= r_xmin;
              if (r_y == r_ymax) r_state <= S_DRAIN;
              else               r_y     <= r_y + COORD_W'(1);
            end else begin
              r_x <= r_x + COORD_W'(1);
            end
          end
        end

        S_DRAIN: begin
          if (w_adv) begin
            pix_valid <= 1'b0;
            r_state   <= S_DONE;
          end
        end

        S_DONE: begin
          tri_done <= 1'b1;
          busy_out <= 1'b0;
          r_state  <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_rasterizer.sv
module tb_triangle_rasterizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [54:0] tri_in;
  logic        busy_out;
  logic        pix_valid;
  logic        pix_ready;
  logic [5:0]  pix_x, pix_y;
  logic [8:0]  pix_z;
  logic [9:0]  pix_color;
  logic        tri_done;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  int ready_mode = 0;   // 0: always ready, 1: pattern 1,0,0 repeating, 2: random
  int ready_ph   = 0;
  int done_cnt   = 0;

  logic [30:0] got_q [$];
  logic [30:0] exp_q [$];
  logic        prev_stall = 1'b0;
  logic [31:0] held;

  triangle_rasterizer dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .tri_in    (tri_in),
    .busy_out  (busy_out),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_z     (pix_z),
    .pix_color (pix_color),
    .tri_done  (tri_done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ready driver: changes only just after a rising edge
  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: pix_ready = 1'b1;
        1: begin
          ready_ph  = (ready_ph + 1) % 3;
          pix_ready = (ready_ph == 0);
        end
        default: pix_ready = 1'($urandom % 2);
      endcase
    end
  end

  // Monitor on the falling edge: records handshakes, counts tri_done, checks hold while stalled
  always @(negedge clk) begin
    if (prev_stall)
      chk("hold_stable", {pix_valid, pix_x, pix_y, pix_z, pix_color}, held);
    if (!rst && pix_valid && pix_ready)
      got_q.push_back({pix_x, pix_y, pix_z, pix_color});
    if (!rst && tri_done) done_cnt++;
    prev_stall = !rst && pix_valid && !pix_ready;
    held = {pix_valid, pix_x, pix_y, pix_z, pix_color};
  end

  // Reference: every bbox pixel, raster order, kept if the three cross products agree in sign
  task automatic build_exp(input int x1, y1, x2, y2, x3, y3, input int z, c);
    int ax, ay, bx, by, cx, cy, area, e0, e1, e2;
    logic [5:0] px, py;
    logic [8:0] pz;
    logic [9:0] pc;
    exp_q.delete();
    ax = x1 + 32; ay = y1 + 32; bx = x2 + 32; by = y2 + 32; cx = x3 + 32; cy = y3 + 32;
    area = (bx - ax) * (cy - ay) - (by - ay) * (cx - ax);
    if (area == 0) return;
    pz = z[8:0];
    pc = c[9:0];
    for (int y = 0; y < 64; y++) begin
      for (int x = 0; x < 64; x++) begin
        if (x < ax && x < bx && x < cx) continue;
        if (x > ax && x > bx && x > cx) continue;
        if (y < ay && y < by && y < cy) continue;
        if (y > ay && y > by && y > cy) continue;
        e0 = (bx - ax) * (y - ay) - (by - ay) * (x - ax);
        e1 = (cx - bx) * (y - by) - (cy - by) * (x - bx);
        e2 = (ax - cx) * (y - cy) - (ay - cy) * (x - cx);
        if ((e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0)) begin
          px = x[5:0];
          py = y[5:0];
          exp_q.push_back({px, py, pz, pc});
        end
      end
    end
  endtask

  function automatic logic [54:0] pack(input int x1, y1, x2, y2, x3, y3, z, c);
    logic [5:0] a, b, d, e, f, g;
    logic [8:0] zz;
    logic [9:0] cc;
    a = x1[5:0]; b = y1[5:0]; d = x2[5:0]; e = y2[5:0]; f = x3[5:0]; g = y3[5:0];
    zz = z[8:0]; cc = c[9:0];
    return {a, b, d, e, f, g, zz, cc};
  endfunction

  task automatic run_tri(input string tag, input int x1, y1, x2, y2, x3, y3, z, c,
                         input int mode, input int exp_lat, input int exp_n, input bit inject);
    int cyc, guard, n;
    build_exp(x1, y1, x2, y2, x3, y3, z, c);
    ready_mode = mode;
    @(posedge clk);
    #1;
    got_q.delete();
    done_cnt = 0;
    tri_in   = pack(x1, y1, x2, y2, x3, y3, z, c);
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    cyc = 1;
    if (exp_lat > 0) begin
      while (!pix_valid && !tri_done && cyc < 50) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      chk({tag, "_latency"}, cyc, exp_lat);
    end
    if (inject) begin
      repeat (4) @(posedge clk);
      #1;
      tri_in   = 55'($urandom);
      valid_in = 1'b1;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
    end
    guard = 0;
    while (busy_out && guard < 20000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk({tag, "_busy_timeout"}, busy_out, 0);
    @(negedge clk);
    #1;
    chk({tag, "_pix_count"}, got_q.size(), exp_q.size());
    if (exp_n >= 0) chk({tag, "_pix_count_spec"}, got_q.size(), exp_n);
    chk({tag, "_tri_done_count"}, done_cnt, 1);
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_pixel"}, got_q[i], exp_q[i]);
  endtask

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    tri_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy_out, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_tri_done", tri_done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_pix_xy", {pix_x, pix_y, pix_z, pix_color}, 0);
    rst = 1'b0;

    // Basic triangle, clean ready
    run_tri("t1", 0, 0, 3, 0, 0, 3, 5, 'h3FF, 0, 3, 10, 0);
    if (got_q.size() > 0) chk("t1_first_pix", got_q[0][30:19], {6'd32, 6'd32});
    // Opposite winding
    run_tri("t2", 0, 0, 0, 3, 3, 0, 5, 'h3FF, 0, 0, 10, 0);
    // Degenerate collinear
    run_tri("t3", 1, 1, 2, 2, 3, 3, 7, 'h055, 0, 3, 0, 0);
    // Back-pressure pattern 1,0,0
    run_tri("t4", 0, 0, 3, 0, 0, 3, 5, 'h3FF, 1, 0, 10, 0);
    chk("ovf_clear", overflow, 0);
    // Triangle arriving mid-scan is dropped and flagged
    run_tri("t6ovf", 0, 0, 3, 0, 0, 3, 9, 'h123, 0, 0, 10, 1);
    chk("ovf_set", overflow, 1);
    // Full-screen corner triangle
    run_tri("t5", -32, -32, 31, -32, -32, 31, 'h1AB, 'h2C3, 0, 0, 2080, 0);
    if (got_q.size() > 0) begin
      chk("t5_first_pix", got_q[0][30:19], {6'd0, 6'd0});
      chk("t5_last_pix", got_q[got_q.size()-1][30:19], {6'd0, 6'd63});
    end
    chk("ovf_sticky", overflow, 1);

    // Reset in the middle of a scan
    ready_mode = 0;
    @(posedge clk);
    #1;
    tri_in   = pack(-32, -32, 31, -32, -32, 31, 1, 1);
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("midscan_busy", busy_out, 1);
    done_cnt = 0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_busy", busy_out, 0);
    chk("midrst_pix_valid", pix_valid, 0);
    chk("midrst_overflow", overflow, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_idle_pix", pix_valid, 0);
    run_tri("t_after_rst", 0, 0, 3, 0, 0, 3, 5, 'h3FF, 0, 3, 10, 0);

    // Random triangles against the reference, random back-pressure
    for (int k = 0; k < 6; k++) begin
      run_tri("rand", int'($urandom_range(0, 31)) - 16, int'($urandom_range(0, 31)) - 16,
              int'($urandom_range(0, 31)) - 16, int'($urandom_range(0, 31)) - 16,
              int'($urandom_range(0, 31)) - 16, int'($urandom_range(0, 31)) - 16,
              int'($urandom_range(0, 511)), int'($urandom_range(0, 1023)), 2, 0, -1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
